// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// encodings, controller state encodings, record layout and small helpers.
package hazard_ctrl_pkg;

    // Register specifier width and derived widths
    localparam int REG_W = 5;
    localparam int FWD_W = 2;
    localparam int CNT_W = 4;

    // Operand mux select encodings
    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

    // Controller state encodings
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // One record per pipeline stage, describing what the instruction there writes
    typedef struct packed {
        logic             valid;
        logic             wrEn;
        logic [REG_W-1:0] dst;
        logic             isLoad;
    } pipe_rec_t;

    // An empty slot in the pipeline
    localparam pipe_rec_t REC_BUBBLE = '{valid: 1'b0, wrEn: 1'b0, dst: '0, isLoad: 1'b0};

    // True when the record holds a live instruction that writes register src
    function automatic logic recWrites(input pipe_rec_t rec, input logic [REG_W-1:0] src);
        return rec.valid && rec.wrEn && (rec.dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// Forwarding selector for one source operand: picks the youngest in-flight
// producer of the register, falling back to the register file.
module fwd_match
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] srcReg_i,
    input  logic             useSrc_i,
    input  pipe_rec_t        exRec_i,
    input  pipe_rec_t        memRec_i,
    input  pipe_rec_t        wbRec_i,
    output logic [FWD_W-1:0] sel_o
);

    // Priority search EX > MEM > WB; r0 and unused operands never forward, and
    // a load in EX has no result yet, so it is skipped in favour of older stages
    always_comb begin
        sel_o = FWD_RF;
        if (!useSrc_i || (srcReg_i == '0)) begin
            sel_o = FWD_RF;
        end else if (recWrites(exRec_i, srcReg_i) && !exRec_i.isLoad) begin
            sel_o = FWD_EX;
        end else if (recWrites(memRec_i, srcReg_i)) begin
            sel_o = FWD_MEM;
        end else if (recWrites(wbRec_i, srcReg_i)) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stalls, branch
// flushes and multi-cycle MDU occupancy of the EX stage.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_is_load,
    input  logic             id_is_mdu,
    input  logic             ex_branch_taken,
    output logic [FWD_W-1:0] fwd_a_sel,
    output logic [FWD_W-1:0] fwd_b_sel,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             ex_hold,
    output logic             exmem_bubble
);

    localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pipe_rec_t        exRec_q, exRec_d;
    pipe_rec_t        memRec_q, memRec_d;
    pipe_rec_t        wbRec_q, wbRec_d;
    logic             postRst_q;

    pipe_rec_t        idRec;
    logic             inRun;
    logic             quiet;
    logic             rsHit;
    logic             rtHit;
    logic             branchFlush;
    logic             loadUse;
    logic             busyHold;
    logic             mduEntry;
    logic [FWD_W-1:0] selA;
    logic [FWD_W-1:0] selB;

    fwd_match u_fwd_a (
        .srcReg_i (id_rs),
        .useSrc_i (id_use_rs),
        .exRec_i  (exRec_q),
        .memRec_i (memRec_q),
        .wbRec_i  (wbRec_q),
        .sel_o    (selA)
    );

    fwd_match u_fwd_b (
        .srcReg_i (id_rt),
        .useSrc_i (id_use_rt),
        .exRec_i  (exRec_q),
        .memRec_i (memRec_q),
        .wbRec_i  (wbRec_q),
        .sel_o    (selB)
    );

    // Hazard detection; reset and the cycle right after it are kept silent
    always_comb begin
        idRec       = '{valid: id_valid, wrEn: id_wr_en, dst: id_wr_reg, isLoad: id_is_load};
        inRun       = (state_q == ST_RUN);
        quiet       = rst || postRst_q;
        rsHit       = id_use_rs && (id_rs != '0) && (id_rs == exRec_q.dst);
        rtHit       = id_use_rt && (id_rt != '0) && (id_rt == exRec_q.dst);
        branchFlush = inRun && !quiet && ex_branch_taken;
        loadUse     = inRun && !quiet && !branchFlush && id_valid &&
                      exRec_q.valid && exRec_q.isLoad && (rsHit || rtHit);
        busyHold    = !inRun && !rst;
        mduEntry    = inRun && !rst && id_valid && id_is_mdu && !branchFlush && !loadUse;
    end

    // Drive the pipeline control outputs; selects stay live in every state
    always_comb begin
        pc_stall     = loadUse || busyHold;
        ifid_stall   = loadUse || busyHold;
        ifid_flush   = branchFlush;
        idex_flush   = branchFlush || loadUse;
        ex_hold      = busyHold;
        exmem_bubble = busyHold;
        fwd_a_sel    = rst ? FWD_RF : selA;
        fwd_b_sel    = rst ? FWD_RF : selB;
    end

    // Advance the shadow records in step with the real pipeline registers
    always_comb begin
        if (ex_hold) begin
            exRec_d = exRec_q;
        end else if (idex_flush) begin
            exRec_d = REC_BUBBLE;
        end else begin
            exRec_d = idRec;
        end
        memRec_d = exmem_bubble ? REC_BUBBLE : exRec_q;
        wbRec_d  = memRec_q;
    end

    // MDU occupancy: count down the remaining EX cycles while BUSY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (inRun) begin
            if (mduEntry) begin
                state_d = ST_BUSY;
                cnt_d   = MDU_LOAD;
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // State registers with synchronous reset that overrides any pending event
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            exRec_q   <= REC_BUBBLE;
            memRec_q  <= REC_BUBBLE;
            wbRec_q   <= REC_BUBBLE;
            postRst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exRec_q   <= exRec_d;
            memRec_q  <= memRec_d;
            wbRec_q   <= wbRec_d;
            postRst_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, all checked against a behavioural pipeline model.
module tb_hazard_ctrl;

    localparam int MDU_CYCLES = 4;
    localparam int RAND_CYCLES = 3000;

    typedef struct {
        bit r;
        bit v;
        int rs;
        int rt;
        bit urs;
        bit urt;
        bit wen;
        int wreg;
        bit ld;
        bit mdu;
        bit br;
    } stim_t;

    typedef struct {
        bit valid;
        bit wr;
        int dst;
        bit ld;
    } mrec_t;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_wr_en;
    logic [4:0] id_wr_reg;
    logic       id_is_load;
    logic       id_is_mdu;
    logic       ex_branch_taken;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       pc_stall;
    logic       ifid_stall;
    logic       ifid_flush;
    logic       idex_flush;
    logic       ex_hold;
    logic       exmem_bubble;

    int testCount  = 0;
    int errorCount = 0;

    // Model: what each stage holds, and how many more cycles the MDU op keeps EX
    mrec_t mEx, mMem, mWb;
    int    mduLeft  = 0;
    bit    mPostRst = 0;

    hazard_ctrl #(.MDU_CYCLES(MDU_CYCLES)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_wr_en        (id_wr_en),
        .id_wr_reg       (id_wr_reg),
        .id_is_load      (id_is_load),
        .id_is_mdu       (id_is_mdu),
        .ex_branch_taken (ex_branch_taken),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .ex_hold         (ex_hold),
        .exmem_bubble    (exmem_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic mrec_t bubble();
        mrec_t b;
        b.valid = 0;
        b.wr    = 0;
        b.dst   = 0;
        b.ld    = 0;
        return b;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s.r = 0; s.v = 0; s.rs = 0; s.rt = 0; s.urs = 0; s.urt = 0;
        s.wen = 0; s.wreg = 0; s.ld = 0; s.mdu = 0; s.br = 0;
        return s;
    endfunction

    function automatic bit produces(input mrec_t rec, input int src);
        return rec.valid && rec.wr && (rec.dst == src);
    endfunction

    // Youngest producer wins; a load in EX cannot supply its value yet
    function automatic int expectedFwd(input int src, input bit used);
        if (!used || src == 0) return 0;
        if (produces(mEx, src) && !mEx.ld) return 1;
        if (produces(mMem, src)) return 2;
        if (produces(mWb, src)) return 3;
        return 0;
    endfunction

    // Drive one cycle of ID/EX inputs, check every output against the model,
    // then advance the model across the coming clock edge
    task automatic applyStimulus(input stim_t s);
        bit    busy, quiet, flushE, luE;
        mrec_t idRec;
        @(negedge clk);
        rst             = s.r;
        id_valid        = s.v;
        id_rs           = 5'(s.rs);
        id_rt           = 5'(s.rt);
        id_use_rs       = s.urs;
        id_use_rt       = s.urt;
        id_wr_en        = s.wen;
        id_wr_reg       = 5'(s.wreg);
        id_is_load      = s.ld;
        id_is_mdu       = s.mdu;
        ex_branch_taken = s.br;
        #2;
        busy   = (mduLeft > 0) && !s.r;
        quiet  = s.r || mPostRst;
        flushE = !busy && !quiet && s.br;
        luE    = !busy && !quiet && !s.br && s.v && mEx.valid && mEx.ld &&
                 ((s.urs && s.rs != 0 && s.rs == mEx.dst) ||
                  (s.urt && s.rt != 0 && s.rt == mEx.dst));
        checkOutput("fwd_a_sel", int'(fwd_a_sel), s.r ? 0 : expectedFwd(s.rs, s.urs));
        checkOutput("fwd_b_sel", int'(fwd_b_sel), s.r ? 0 : expectedFwd(s.rt, s.urt));
        checkOutput("pc_stall", int'(pc_stall), int'(busy || luE));
        checkOutput("ifid_stall", int'(ifid_stall), int'(busy || luE));
        checkOutput("ifid_flush", int'(ifid_flush), int'(flushE));
        checkOutput("idex_flush", int'(idex_flush), int'(flushE || luE));
        checkOutput("ex_hold", int'(ex_hold), int'(busy));
        checkOutput("exmem_bubble", int'(exmem_bubble), int'(busy));

        idRec.valid = s.v;
        idRec.wr    = s.wen;
        idRec.dst   = s.wreg;
        idRec.ld    = s.ld;
        if (s.r) begin
            mEx      = bubble();
            mMem     = bubble();
            mWb      = bubble();
            mduLeft  = 0;
            mPostRst = 1;
        end else begin
            mPostRst = 0;
            mWb      = mMem;
            if (busy) begin
                mMem    = bubble();
                mduLeft = mduLeft - 1;
            end else begin
                mMem = mEx;
                mEx  = (flushE || luE) ? bubble() : idRec;
                if (s.v && s.mdu && !flushE && !luE) mduLeft = MDU_CYCLES - 1;
            end
        end
    endtask

    initial begin
        stim_t s;
        rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_wr_en = 0; id_wr_reg = 0; id_is_load = 0; id_is_mdu = 0; ex_branch_taken = 0;
        mEx = bubble(); mMem = bubble(); mWb = bubble();

        // Reset, then a quiet cycle
        s = nop(); s.r = 1;
        applyStimulus(s);
        applyStimulus(s);
        checkOutput("rst_pc_stall", int'(pc_stall), 0);
        s = nop();
        applyStimulus(s);

        // add r3 in EX, ID reads r3 through rs
        s = nop(); s.v = 1; s.wen = 1; s.wreg = 3;
        applyStimulus(s);
        s = nop(); s.v = 1; s.rs = 3; s.urs = 1;
        applyStimulus(s);
        checkOutput("dir_fwd_ex", int'(fwd_a_sel), 1);
        checkOutput("dir_no_stall", int'(pc_stall), 0);

        // EX writes r0, ID reads r0
        s = nop(); s.v = 1; s.wen = 1; s.wreg = 0;
        applyStimulus(s);
        s = nop(); s.v = 1; s.rs = 0; s.urs = 1;
        applyStimulus(s);
        checkOutput("dir_r0_sel", int'(fwd_a_sel), 0);

        // lw r5 then a user of r5 via rt: one stall cycle, then MEM forward
        s = nop(); s.v = 1; s.wen = 1; s.wreg = 5; s.ld = 1;
        applyStimulus(s);
        s = nop(); s.v = 1; s.rt = 5; s.urt = 1;
        applyStimulus(s);
        checkOutput("dir_lu_stall", int'(pc_stall), 1);
        checkOutput("dir_lu_flush", int'(idex_flush), 1);
        applyStimulus(s);
        checkOutput("dir_lu_released", int'(pc_stall), 0);
        checkOutput("dir_lu_fwd_mem", int'(fwd_b_sel), 2);

        // Taken branch coincident with a load-use hazard
        s = nop(); s.v = 1; s.wen = 1; s.wreg = 6; s.ld = 1;
        applyStimulus(s);
        s = nop(); s.v = 1; s.rs = 6; s.urs = 1; s.br = 1;
        applyStimulus(s);
        checkOutput("dir_br_ifid_flush", int'(ifid_flush), 1);
        checkOutput("dir_br_idex_flush", int'(idex_flush), 1);
        checkOutput("dir_br_no_stall", int'(pc_stall), 0);

        // mul holds EX for MDU_CYCLES-1 cycles, released on the last one
        s = nop(); s.v = 1; s.wen = 1; s.wreg = 7; s.mdu = 1;
        applyStimulus(s);
        s = nop(); s.v = 1; s.rs = 2; s.urs = 1;
        for (int i = 0; i < MDU_CYCLES; i++) begin
            applyStimulus(s);
            checkOutput("dir_mdu_hold", int'(ex_hold), (i < MDU_CYCLES - 1) ? 1 : 0);
            checkOutput("dir_mdu_bubble", int'(exmem_bubble), (i < MDU_CYCLES - 1) ? 1 : 0);
        end

        // Reset in the middle of BUSY, with a branch in the following cycle
        s = nop(); s.v = 1; s.wen = 1; s.wreg = 7; s.mdu = 1;
        applyStimulus(s);
        s = nop();
        applyStimulus(s);
        s = nop(); s.r = 1;
        applyStimulus(s);
        checkOutput("dir_rst_busy_hold", int'(ex_hold), 0);
        s = nop(); s.v = 1; s.rs = 7; s.urs = 1; s.br = 1;
        applyStimulus(s);
        checkOutput("dir_post_rst_stall", int'(pc_stall), 0);
        checkOutput("dir_post_rst_flush", int'(ifid_flush), 0);
        checkOutput("dir_post_rst_sel", int'(fwd_a_sel), 0);

        // Randomized traffic over a small register set to provoke matches
        for (int n = 0; n < RAND_CYCLES; n++) begin
            s.r    = ($urandom_range(0, 63) == 0);
            s.v    = ($urandom_range(0, 7) != 0);
            s.rs   = $urandom_range(0, 3);
            s.rt   = $urandom_range(0, 3);
            s.urs  = ($urandom_range(0, 3) != 0);
            s.urt  = ($urandom_range(0, 1) != 0);
            s.wen  = ($urandom_range(0, 3) != 0);
            s.wreg = $urandom_range(0, 3);
            s.ld   = ($urandom_range(0, 3) == 0);
            s.mdu  = ($urandom_range(0, 9) == 0);
            s.br   = ($urandom_range(0, 7) == 0);
            applyStimulus(s);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, errorCount);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MDU_CYCLES, default 4 (legal range 2..15), is the number of cycles an MDU instruction occupies EX.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 id_valid  input  1  ID stage holds a real instruction.
REQ-005 id_rs, id_rt  input  5 each  ID source register numbers.
REQ-006 id_use_rs, id_use_rt  input  1 each  ID instruction reads rs / rt.
REQ-007 id_wr_en, id_wr_reg  input  1, 5  ID instruction writes register id_wr_reg.
REQ-008 id_is_load, id_is_mdu  input  1 each  ID instruction is a load / multi-cycle MDU op.
REQ-009 ex_branch_taken  input  1  EX resolved a taken branch this cycle.
REQ-010 fwd_a_sel, fwd_b_sel  output  2 each  operand selects for the 4:1 operand muxes: 00 regfile, 01 EX result, 10 MEM result, 11 WB result.
REQ-011 pc_stall, ifid_stall  output  1 each  hold PC / IF-ID register.
REQ-012 ifid_flush, idex_flush  output  1 each  load bubble into IF-ID / ID-EX.
REQ-013 ex_hold, exmem_bubble  output  1 each  hold ID-EX contents / load bubble into EX-MEM.

Function
REQ-014 Block SHALL keep three records ex_rec, mem_rec, wb_rec, each {valid, wr_en, dst[4:0], is_load}, mirroring the pipeline.
REQ-015 Each edge, wb_rec <= mem_rec; mem_rec <= bubble if exmem_bubble, else ex_rec.
REQ-016 ex_rec SHALL be held if ex_hold, load bubble if idex_flush, else load ID fields with valid=id_valid.
REQ-017 fwd_a_sel (on id_rs, id_use_rs), combinational, first match wins: rs=0 or not used -> 00; ex_rec valid, wr_en, dst=rs, not load -> 01; mem_rec match -> 10; wb_rec match -> 11; else 00. fwd_b_sel identical on id_rt/id_use_rt.
REQ-018 Load-use: ex_rec valid load with dst matching a used nonzero rs/rt of a valid ID instruction SHALL assert pc_stall, ifid_stall, idex_flush for exactly one cycle.
REQ-019 Flush: ex_branch_taken in RUN SHALL assert ifid_flush and idex_flush, suppress load-use stall, and prevent MDU entry.
REQ-020 FSM states RUN, BUSY; 4-bit counter cnt.
REQ-021 RUN->BUSY at an edge where a valid id_is_mdu instruction transfers into ex_rec (no stall, no flush); cnt <= MDU_CYCLES-1.
REQ-022 In BUSY: pc_stall, ifid_stall, ex_hold, exmem_bubble = 1; idex_flush, ifid_flush = 0; ex_branch_taken and load-use ignored; cnt decrements; cnt=1 -> RUN next edge.
REQ-023 MDU instruction SHALL therefore occupy EX exactly MDU_CYCLES cycles; its final cycle is RUN with no stall, and must not re-trigger BUSY.
REQ-024 Forward selects SHALL remain computed in every state.
REQ-025 All stall/flush outputs 0 in RUN absent hazard or flush.

Reset
REQ-026 rst SHALL clear all record valid bits, state <= RUN, cnt <= 0, overriding any event in that cycle, including mid-BUSY.
REQ-027 During and one cycle after reset: all stall/flush/hold outputs 0, fwd selects 00.

Structure
REQ-028 Shared package/header SHALL hold fwd select encodings (FWD_RF/EX/MEM/WB), FSM state encodings, and record field widths.
REQ-029 One sub-module, fwd_match, computes one 2-bit select from a source register and the three records; instantiated twice.

Verification
REQ-030 add r3 in EX, ID reads rs=r3 -> fwd_a_sel=01, no stall.
REQ-031 lw r5 in EX, ID uses rt=r5 -> one cycle pc_stall=ifid_stall=idex_flush=1, next cycle fwd_b_sel=10.
REQ-032 rs=r0 with EX writing r0 -> fwd_a_sel=00.
REQ-033 MDU_CYCLES=4, mul enters EX -> ex_hold=1 for 3 cycles, released 4th; mem_rec bubbles for 3 edges.
REQ-034 ex_branch_taken=1 coincident with load-use hazard -> ifid_flush=idex_flush=1, pc_stall=0.
REQ-035 rst asserted at cnt=2 in BUSY -> next cycle RUN, all stall outputs 0, selects 00.
